neuron_serijski_mac: RTL and testbench

//  Parametrised, time-multiplexed successor to the fully parallel hidden-layer neurons: one sign-magnitude MAC per cycle over N_ULAZA inputs.

---
 rtl/neuron_pkg.sv | 27 ++
 rtl/neuron_serijski_mac_sigmoid_lut.sv | 51 +++++
 rtl/neuron_serijski_mac.sv | 163 ++++++++++++++++
 tb/tb_neuron_serijski_mac.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the serial hidden-layer neuron.
//   W       : width of samples, weights, products and the sigmoid output
//   SUMA_W  : magnitude width presented to Sigmoid_LUT
//   stanje_e: FSM state encoding of the serial MAC
//   sm_sign / sm_mag : field helpers for sign-magnitude weights
package neuron_pkg;

  localparam int W      = 16;
  localparam int SUMA_W = 22;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_ZNAK  = 2'd2,
    S_IZLAZ = 2'd3
  } stanje_e;

  // Sign-magnitude weight: bit W-1 is the sign (1 = negative), the rest is magnitude.
  function automatic logic sm_sign(input logic [W-1:0] v);
    return v[W-1];
  endfunction

  function automatic logic [W-2:0] sm_mag(input logic [W-1:0] v);
    return v[W-2:0];
  endfunction

endpackage

// File: rtl/neuron_serijski_mac_sigmoid_lut.sv
// Sigmoid_LUT: combinational sigmoid of a sign-magnitude sum.
//   suma         in  SUMA_W  |sum|, fixed point with 16 fractional bits
//   predznak     in  1       sign of the sum (1 = negative)
//   vjerojatnost out W       probability, unsigned Q0.16
// The positive half is a 16-entry table of sigmoid(i * 0.5), i = 0..15,
// indexed by suma in steps of 0.5; anything past 7.5 uses the last entry.
// The negative half uses the symmetry sigmoid(-x) = 1 - sigmoid(x).
module Sigmoid_LUT
  import neuron_pkg::*;
(
  input  logic [SUMA_W-1:0] suma,
  input  logic              predznak,
  output logic [W-1:0]      vjerojatnost
);

  localparam int SEG_SHIFT = 15;               // one table step = 0.5
  localparam int SEG_W     = SUMA_W - SEG_SHIFT;

  logic [SEG_W-1:0] seg_raw;
  logic [3:0]       seg;
  logic [W-1:0]     poz;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path through the block leaves it unassigned and no latch is inferred.
    poz     = 16'h8000;
    seg_raw = SEG_W'(suma >> SEG_SHIFT);
    seg     = (|seg_raw[SEG_W-1:4]) ? 4'd15 : seg_raw[3:0];
    unique case (seg)
      4'd0:  poz = 16'h8000;
      4'd1:  poz = 16'h9F59;
      4'd2:  poz = 16'hBB27;
      4'd3:  poz = 16'hD14D;
      4'd4:  poz = 16'hE17D;
      4'd5:  poz = 16'hEC94;
      4'd6:  poz = 16'hF3DC;
      4'd7:  poz = 16'hF87F;
      4'd8:  poz = 16'hFB65;
      4'd9:  poz = 16'hFD29;
      4'd10: poz = 16'hFE49;
      4'd11: poz = 16'hFEF5;
      4'd12: poz = 16'hFF5E;
      4'd13: poz = 16'hFF9E;
      4'd14: poz = 16'hFFC4;
      4'd15: poz = 16'hFFDC;
    endcase
    // 1 - p in Q0.16 is the two's complement of p modulo 2^16.
    vjerojatnost = predznak ? (~poz + W'(1)) : poz;
  end

endmodule

// File: rtl/neuron_serijski_mac.sv
// neuron_serijski_mac: time-multiplexed hidden-layer neuron.
// One sign-magnitude multiply-accumulate per cycle over N_ULAZA samples,
// weights held in a run-time writable register file, result passed through
// Sigmoid_LUT.
//   clk, rst                 clock, synchronous active-high reset
//   uzorak / _valid / _ready sample vector in, accepted on valid && ready
//   tez_we/tez_addr/tez_data weight write port (sign-magnitude weight)
//   izlaz / izlaz_valid      sigmoid output, one-cycle valid pulse
//   suma / predznak          debug: clipped |sum| and sign of the last result
// Timing: accept at cycle 0 -> izlaz_valid at cycle N_ULAZA+2; next accept
// possible at N_ULAZA+3. W and SUMA_W come from neuron_pkg because
// Sigmoid_LUT is built for them. N_ULAZA must be at least 2.
module neuron_serijski_mac
  import neuron_pkg::*;
#(
  parameter  int N_ULAZA = 60,
  parameter  int P_FRAC  = 15,
  parameter  int ACC_W   = 24,
  localparam int IDX_W   = $clog2(N_ULAZA)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_ULAZA*W-1:0] uzorak,
  input  logic                 uzorak_valid,
  output logic                 uzorak_ready,
  input  logic                 tez_we,
  input  logic [IDX_W-1:0]     tez_addr,
  input  logic [W-1:0]         tez_data,
  output logic [W-1:0]         izlaz,
  output logic                 izlaz_valid,
  output logic [SUMA_W-1:0]    suma,
  output logic                 predznak
);

  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(N_ULAZA - 1);
  localparam logic signed [ACC_W:0] ACC_MAX = {2'b00, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] ACC_MIN = {2'b11, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W:0]      SUMA_MAX = {{(ACC_W+1-SUMA_W){1'b0}}, {SUMA_W{1'b1}}};

  stanje_e                 stanje_q, stanje_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [N_ULAZA*W-1:0]    uzorak_q;
  logic [W-1:0]            tez_q [N_ULAZA];
  logic [SUMA_W-1:0]       suma_q, suma_d;
  logic                    predznak_q, predznak_d;
  logic [W-1:0]            izlaz_q, izlaz_d;
  logic                    izlaz_valid_q, izlaz_valid_d;

  logic                    prihvat;
  logic [W-1:0]            x_k, w_k, p_k;
  logic [2*W-2:0]          proizvod;
  logic signed [ACC_W:0]   acc_ext, p_ext, zbroj, acc_sat;
  logic [ACC_W:0]          modul;
  logic [SUMA_W-1:0]       suma_klip;
  logic [W-1:0]            lut_izlaz;

  assign uzorak_ready = (stanje_q == S_IDLE);
  assign prihvat      = uzorak_valid && (stanje_q == S_IDLE);

  // Single shared multiplier and saturating accumulator.
  always_comb begin
    x_k      = uzorak_q[idx_q*W +: W];
    w_k      = tez_q[idx_q];
    proizvod = {{W{1'b0}}, sm_mag(w_k)} * {{(W-1){1'b0}}, x_k};
    p_k      = W'(proizvod >> P_FRAC);
    acc_ext  = {acc_q[ACC_W-1], acc_q};
    p_ext    = {{(ACC_W+1-W){1'b0}}, p_k};
    zbroj    = sm_sign(w_k) ? (acc_ext - p_ext) : (acc_ext + p_ext);
    // One guard bit makes overflow visible, so clamp instead of wrapping.
    if (zbroj > ACC_MAX)      acc_sat = ACC_MAX;
    else if (zbroj < ACC_MIN) acc_sat = ACC_MIN;
    else                      acc_sat = zbroj;
    // Negating in ACC_W+1 bits keeps |most-negative| representable.
    modul     = acc_q[ACC_W-1] ? -acc_ext : acc_ext;
    suma_klip = (modul > SUMA_MAX) ? {SUMA_W{1'b1}} : modul[SUMA_W-1:0];
  end

  Sigmoid_LUT u_sigmoid (
    .suma         (suma_q),
    .predznak     (predznak_q),
    .vjerojatnost (lut_izlaz)
  );

  always_comb begin
    stanje_d      = stanje_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    suma_d        = suma_q;
    predznak_d    = predznak_q;
    izlaz_d       = izlaz_q;
    izlaz_valid_d = 1'b0;
    unique case (stanje_q)
      S_IDLE: begin
        if (prihvat) begin
          stanje_d = S_MAC;
          idx_d    = '0;
          acc_d    = '0;
        end
      end
      S_MAC: begin
        acc_d = acc_sat[ACC_W-1:0];
        if (idx_q == IDX_LAST) stanje_d = S_ZNAK;
        else                   idx_d    = idx_q + IDX_W'(1);
      end
      S_ZNAK: begin
        predznak_d = acc_q[ACC_W-1];
        suma_d     = suma_klip;
        stanje_d   = S_IZLAZ;
      end
      S_IZLAZ: begin
        izlaz_d       = lut_izlaz;
        izlaz_valid_d = 1'b1;
        stanje_d      = S_IDLE;
      end
      default: stanje_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      stanje_q      <= S_IDLE;
      idx_q         <= '0;
      acc_q         <= '0;
      suma_q        <= '0;
      predznak_q    <= 1'b0;
      izlaz_q       <= '0;
      izlaz_valid_q <= 1'b0;
    end else begin
      stanje_q      <= stanje_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      suma_q        <= suma_d;
      predznak_q    <= predznak_d;
      izlaz_q       <= izlaz_d;
      izlaz_valid_q <= izlaz_valid_d;
    end
  end

  // NOTE: the weight file must read as zero after reset, so it is built from
  // resettable flops; the captured sample vector is pure data and is only
  // ever read after a capture, so it carries no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N_ULAZA; k++) tez_q[k] <= '0;
    end else if (tez_we && ({1'b0, tez_addr} < (IDX_W+1)'(N_ULAZA))) begin
      // The MAC read in the same cycle still sees the old weight.
      tez_q[tez_addr] <= tez_data;
    end
  end

  always_ff @(posedge clk) begin
    if (prihvat) uzorak_q <= uzorak;
  end

  assign izlaz       = izlaz_q;
  assign izlaz_valid = izlaz_valid_q;
  assign suma        = suma_q;
  assign predznak    = predznak_q;

endmodule

// File: tb/tb_neuron_serijski_mac.sv
module tb_neuron_serijski_mac;

  localparam int W  = 16;
  localparam int N0 = 60;
  localparam int NA = 70;
  localparam int NB = 130;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Default instance (N_ULAZA = 60)
  logic [N0*W-1:0] uz0 = '0;
  logic uz0_valid = 1'b0, uz0_ready;
  logic we0 = 1'b0;
  logic [5:0] wa0 = '0;
  logic [15:0] wd0 = '0, izl0;
  logic izv0, pred0;
  logic [21:0] suma0;

  neuron_serijski_mac dut (
    .clk(clk), .rst(rst), .uzorak(uz0), .uzorak_valid(uz0_valid), .uzorak_ready(uz0_ready),
    .tez_we(we0), .tez_addr(wa0), .tez_data(wd0), .izlaz(izl0), .izlaz_valid(izv0),
    .suma(suma0), .predznak(pred0));

  // N_ULAZA = 70: |sum| exceeds SUMA_W, accumulator does not saturate
  logic [NA*W-1:0] uza = '0;
  logic uza_valid = 1'b0, uza_ready;
  logic wea = 1'b0;
  logic [6:0] waa = '0;
  logic [15:0] wda = '0, izla;
  logic izva, preda;
  logic [21:0] sumaa;

  neuron_serijski_mac #(.N_ULAZA(NA)) dut70 (
    .clk(clk), .rst(rst), .uzorak(uza), .uzorak_valid(uza_valid), .uzorak_ready(uza_ready),
    .tez_we(wea), .tez_addr(waa), .tez_data(wda), .izlaz(izla), .izlaz_valid(izva),
    .suma(sumaa), .predznak(preda));

  // N_ULAZA = 130: accumulator saturates in both directions
  logic [NB*W-1:0] uzb = '0;
  logic uzb_valid = 1'b0, uzb_ready;
  logic web = 1'b0;
  logic [7:0] wab = '0;
  logic [15:0] wdb = '0, izlb;
  logic izvb, predb;
  logic [21:0] sumab;

  neuron_serijski_mac #(.N_ULAZA(NB)) dut130 (
    .clk(clk), .rst(rst), .uzorak(uzb), .uzorak_valid(uzb_valid), .uzorak_ready(uzb_ready),
    .tez_we(web), .tez_addr(wab), .tez_data(wdb), .izlaz(izlb), .izlaz_valid(izvb),
    .suma(sumab), .predznak(predb));

  // All tasks start and end 1 time unit after a rising edge.
  task automatic write_w0(input logic [5:0] a, input logic [15:0] d);
    we0 = 1'b1; wa0 = a; wd0 = d;
    @(posedge clk); #1;
    we0 = 1'b0;
  endtask

  // Sends one vector to the default instance and waits for izlaz_valid.
  // Optionally drives one weight write while idx == wr_cyc.
  // lat = cycles from accept to izlaz_valid (-1 on timeout).
  task automatic run_vec(input logic [N0*W-1:0] v, input bit do_wr, input int wr_cyc,
                         input logic [5:0] wa, input logic [15:0] wd,
                         output int lat, output logic rdy1);
    lat = -1;
    rdy1 = 1'bx;
    uz0 = v; uz0_valid = 1'b1;
    @(posedge clk); #1;
    uz0_valid = 1'b0;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      we0 = 1'b0;
      if (c == 1) rdy1 = uz0_ready;
      if (izv0) begin lat = c; break; end
      if (do_wr && c == wr_cyc) begin we0 = 1'b1; wa0 = wa; wd0 = wd; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_total++; if (izl0 !== 16'h0) $display("FAIL reset_izlaz: got %h want 0000", izl0); else n_pass++;
    n_total++; if (izv0 !== 1'b0) $display("FAIL reset_izlaz_valid: got %b want 0", izv0); else n_pass++;
    n_total++; if (uz0_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", uz0_ready); else n_pass++;
    n_total++; if (suma0 !== 22'h0 || pred0 !== 1'b0) $display("FAIL reset_debug: got %h/%b want 000000/0", suma0, pred0); else n_pass++;
    rst = 1'b0;
  endtask

  task automatic test_zero_weights();
    int lat; logic rdy1;
    run_vec({N0{16'h1234}}, 1'b0, 0, '0, '0, lat, rdy1);
    n_total++; if (lat !== 62) $display("FAIL zero_latency: got %0d want 62", lat); else n_pass++;
    n_total++; if (rdy1 !== 1'b0) $display("FAIL zero_ready_busy: got %b want 0", rdy1); else n_pass++;
    n_total++; if (suma0 !== 22'h0 || pred0 !== 1'b0) $display("FAIL zero_sum: got %h/%b want 000000/0", suma0, pred0); else n_pass++;
    n_total++; if (izl0 !== 16'h8000) $display("FAIL zero_izlaz: got %h want 8000", izl0); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (izv0 !== 1'b0) $display("FAIL zero_pulse_width: got %b want 0", izv0); else n_pass++;
    n_total++; if (uz0_ready !== 1'b1 || izl0 !== 16'h8000) $display("FAIL zero_hold: got ready=%b izlaz=%h want 1/8000", uz0_ready, izl0); else n_pass++;
  endtask

  task automatic test_single_term();
    int lat; logic rdy1; logic [N0*W-1:0] v;
    write_w0(6'd0, 16'h4000);
    v = '0; v[0 +: 16] = 16'h0100;
    // (0x4000 * 0x0100) >> 15 = 0x80
    run_vec(v, 1'b0, 0, '0, '0, lat, rdy1);
    n_total++; if (suma0 !== 22'h80 || pred0 !== 1'b0) $display("FAIL single_sum: got %h/%b want 000080/0", suma0, pred0); else n_pass++;
    n_total++; if (izl0 !== 16'h8000) $display("FAIL single_izlaz: got %h want 8000", izl0); else n_pass++;
  endtask

  task automatic test_sign_mag();
    int lat; logic rdy1; logic [N0*W-1:0] v;
    // 0x80 - (0x4000 * 0x0200 >> 15 = 0x100) = -0x80
    write_w0(6'd1, 16'hC000);
    v = '0; v[0 +: 16] = 16'h0100; v[16 +: 16] = 16'h0200;
    run_vec(v, 1'b0, 0, '0, '0, lat, rdy1);
    n_total++; if (suma0 !== 22'h80 || pred0 !== 1'b1) $display("FAIL neg_sum: got %h/%b want 000080/1", suma0, pred0); else n_pass++;
    n_total++; if (izl0 !== 16'h8000) $display("FAIL neg_izlaz: got %h want 8000", izl0); else n_pass++;
    // -(0x7FFF * 0xFFFF >> 15) = -0xFFFD; writes to addresses 60 and 63 are ignored
    write_w0(6'd0, 16'hFFFF);
    write_w0(6'd1, 16'h0000);
    write_w0(6'd60, 16'h7FFF);
    write_w0(6'd63, 16'h7FFF);
    run_vec({N0{16'hFFFF}}, 1'b0, 0, '0, '0, lat, rdy1);
    n_total++; if (suma0 !== 22'hFFFD || pred0 !== 1'b1) $display("FAIL neg_big_sum: got %h/%b want 00fffd/1", suma0, pred0); else n_pass++;
    n_total++; if (izl0 !== 16'h60A7) $display("FAIL neg_big_izlaz: got %h want 60a7", izl0); else n_pass++;
    // 2 * 0xFFFD = 0x1FFFA -> table step 3
    write_w0(6'd0, 16'h7FFF);
    write_w0(6'd1, 16'h7FFF);
    v = '0; v[0 +: 16] = 16'hFFFF; v[16 +: 16] = 16'hFFFF;
    run_vec(v, 1'b0, 0, '0, '0, lat, rdy1);
    n_total++; if (suma0 !== 22'h1FFFA || pred0 !== 1'b0) $display("FAIL pos_big_sum: got %h/%b want 01fffa/0", suma0, pred0); else n_pass++;
    n_total++; if (izl0 !== 16'hD14D) $display("FAIL pos_big_izlaz: got %h want d14d", izl0); else n_pass++;
  endtask

  task automatic test_n70_clip();
    int lat = -1;
    for (int k = 0; k < NA; k++) begin
      wea = 1'b1; waa = 7'(k); wda = 16'h7FFF;
      @(posedge clk); #1;
    end
    wea = 1'b0;
    uza = '1; uza_valid = 1'b1;
    @(posedge clk); #1;
    uza_valid = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (izva) begin lat = c; break; end
    end
    // 70 * 0xFFFD = 0x45FF2E > 0x3FFFFF
    n_total++; if (lat !== 72) $display("FAIL n70_latency: got %0d want 72", lat); else n_pass++;
    n_total++; if (sumaa !== 22'h3FFFFF || preda !== 1'b0) $display("FAIL n70_clip: got %h/%b want 3fffff/0", sumaa, preda); else n_pass++;
    n_total++; if (izla !== 16'hFFDC) $display("FAIL n70_izlaz: got %h want ffdc", izla); else n_pass++;
  endtask

  task automatic run_n130(input logic [15:0] wv, output int lat);
    lat = -1;
    for (int k = 0; k < NB; k++) begin
      web = 1'b1; wab = 8'(k); wdb = wv;
      @(posedge clk); #1;
    end
    web = 1'b0;
    uzb = '1; uzb_valid = 1'b1;
    @(posedge clk); #1;
    uzb_valid = 1'b0;
    for (int c = 1; c <= 160; c++) begin
      @(posedge clk); #1;
      if (izvb) begin lat = c; break; end
    end
  endtask

  task automatic test_n130_saturation();
    int lat;
    // 130 * 0xFFFD = 8519290 > 2^23-1: a wrapping accumulator would turn negative
    run_n130(16'h7FFF, lat);
    n_total++; if (lat !== 132) $display("FAIL sat_pos_latency: got %0d want 132", lat); else n_pass++;
    n_total++; if (sumab !== 22'h3FFFFF || predb !== 1'b0) $display("FAIL sat_pos: got %h/%b want 3fffff/0", sumab, predb); else n_pass++;
    n_total++; if (izlb !== 16'hFFDC) $display("FAIL sat_pos_izlaz: got %h want ffdc", izlb); else n_pass++;
    // saturates at -2^23, whose magnitude also clips
    run_n130(16'hFFFF, lat);
    n_total++; if (sumab !== 22'h3FFFFF || predb !== 1'b1) $display("FAIL sat_neg: got %h/%b want 3fffff/1", sumab, predb); else n_pass++;
    n_total++; if (izlb !== 16'h0024) $display("FAIL sat_neg_izlaz: got %h want 0024", izlb); else n_pass++;
  endtask

  task automatic test_rst_mid_mac();
    int lat; logic rdy1; int pulses = 0;
    uz0 = {N0{16'hFFFF}}; uz0_valid = 1'b1;
    @(posedge clk); #1;
    uz0_valid = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (izv0) pulses++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_total++; if (uz0_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", uz0_ready); else n_pass++;
    n_total++; if (izl0 !== 16'h0 || suma0 !== 22'h0) $display("FAIL rstmid_outputs: got %h/%h want 0000/000000", izl0, suma0); else n_pass++;
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (izv0) pulses++;
    end
    n_total++; if (pulses !== 0) $display("FAIL rstmid_no_valid: got %0d pulses want 0", pulses); else n_pass++;
    run_vec({N0{16'hFFFF}}, 1'b0, 0, '0, '0, lat, rdy1);
    n_total++; if (lat !== 62) $display("FAIL rstmid_next_latency: got %0d want 62", lat); else n_pass++;
    n_total++; if (suma0 !== 22'h0 || pred0 !== 1'b0) $display("FAIL rstmid_weights_cleared: got %h/%b want 000000/0", suma0, pred0); else n_pass++;
  endtask

  task automatic test_write_during_mac();
    int lat; logic rdy1; logic [N0*W-1:0] v;
    // w[59] written while idx = 10; (0x0010 * 0x8000) >> 15 = 0x10, negative
    v = '0; v[59*16 +: 16] = 16'h8000;
    run_vec(v, 1'b1, 10, 6'd59, 16'h8010, lat, rdy1);
    n_total++; if (suma0 !== 22'h10 || pred0 !== 1'b1) $display("FAIL wr_ahead: got %h/%b want 000010/1", suma0, pred0); else n_pass++;
    // w[10] rewritten in the cycle it is read: old 0x4000 -> 0x2000, new 0x7FFF would give 0x3FFF
    write_w0(6'd10, 16'h4000);
    v = '0; v[10*16 +: 16] = 16'h4000;
    run_vec(v, 1'b1, 10, 6'd10, 16'h7FFF, lat, rdy1);
    n_total++; if (suma0 !== 22'h2000 || pred0 !== 1'b0) $display("FAIL wr_same_idx_old: got %h/%b want 002000/0", suma0, pred0); else n_pass++;
    run_vec(v, 1'b0, 0, '0, '0, lat, rdy1);
    n_total++; if (suma0 !== 22'h3FFF) $display("FAIL wr_same_idx_new: got %h want 003fff", suma0); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat1 = -1, lat2 = -1;
    logic [21:0] s1 = 'x, s2 = 'x;
    logic [N0*W-1:0] va, vb;
    write_w0(6'd0, 16'h4000);
    va = '0; va[0 +: 16] = 16'h0100;
    vb = '0; vb[0 +: 16] = 16'h0200;
    // valid held high throughout; the vector changes mid-MAC and must not be recaptured
    uz0 = va; uz0_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 160; c++) begin
      @(posedge clk); #1;
      if (c == 20) uz0 = vb;
      if (c == 63) uz0_valid = 1'b0;
      if (izv0) begin
        if (lat1 < 0) begin lat1 = c; s1 = suma0; end
        else begin lat2 = c; s2 = suma0; break; end
      end
    end
    n_total++; if (lat1 !== 62 || s1 !== 22'h80) $display("FAIL b2b_first: got lat=%0d suma=%h want 62/000080", lat1, s1); else n_pass++;
    n_total++; if (lat2 !== 125 || s2 !== 22'h100) $display("FAIL b2b_second: got lat=%0d suma=%h want 125/000100", lat2, s2); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zero_weights();
    test_single_term();
    test_sign_mag();
    test_n70_clip();
    test_n130_saturation();
    test_rst_mid_mac();
    test_write_during_mac();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
